// File: rtl/axi_bw_meter_pkg.sv
// Shared types and saturating arithmetic for the AXI bandwidth meter.
package axi_bw_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [1:0] OKAY_RESP = 2'b00;

    // Widest counter the helper supports; callers zero-extend into this width.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             sat;
    } sat_res_t;

    // Adds inc to val, clipping at 2^width-1; sat flags an increment that was clipped.
    function automatic sat_res_t sat_inc(input logic [MAX_W-1:0] val,
                                         input logic [1:0]       inc,
                                         input int unsigned      width);
        sat_res_t         res;
        logic [MAX_W-1:0] max_v;
        logic [MAX_W-1:0] inc_w;
        max_v     = {MAX_W{1'b1}} >> (MAX_W - width);
        inc_w     = {{(MAX_W-2){1'b0}}, inc};
        res.value = val;
        res.sat   = 1'b0;
        if (inc_w != '0) begin
            if (val > max_v - inc_w) begin
                res.value = max_v;
                res.sat   = 1'b1;
            end else begin
                res.value = val + inc_w;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_bw_ch_cnt.sv
// Per-direction beat/burst counters with first-beat and last-burst timestamps.
module axi_bw_ch_cnt
    import axi_bw_meter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         beat,
    input  logic         burst_end,
    input  logic [W-1:0] k,
    output logic [W-1:0] beats,
    output logic [W-1:0] bursts,
    output logic [W-1:0] first,
    output logic [W-1:0] last,
    output logic         sat
);

    logic [W-1:0] beats_q, beats_d;
    logic [W-1:0] bursts_q, bursts_d;
    logic [W-1:0] first_q, first_d;
    logic [W-1:0] last_q, last_d;
    sat_res_t     beat_res;
    sat_res_t     burst_res;
    logic         unused_wide;

    always_comb begin
        beat_res  = sat_inc(MAX_W'(beats_q), {1'b0, beat}, W);
        burst_res = sat_inc(MAX_W'(bursts_q), {1'b0, burst_end}, W);
        beats_d   = beats_q;
        bursts_d  = bursts_q;
        first_d   = first_q;
        last_d    = last_q;
        if (clear) begin
            beats_d  = '0;
            bursts_d = '0;
            first_d  = '0;
            last_d   = '0;
        end else if (enable) begin
            beats_d  = beat_res.value[W-1:0];
            bursts_d = burst_res.value[W-1:0];
            // A saturated beat counter never returns to zero, so this only fires once per run.
            if (beat && (beats_q == '0)) first_d = k;
            if (burst_end) last_d = k;
        end
    end

    assign sat         = enable & ~clear & (beat_res.sat | burst_res.sat);
    assign unused_wide = ^{beat_res.value, burst_res.value};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            bursts_q <= '0;
            first_q  <= '0;
            last_q   <= '0;
        end else begin
            beats_q  <= beats_d;
            bursts_q <= bursts_d;
            first_q  <= first_d;
            last_q   <= last_d;
        end
    end

    assign beats  = beats_q;
    assign bursts = bursts_q;
    assign first  = first_q;
    assign last   = last_q;

endmodule

// File: rtl/axi_bw_meter.sv
// Passive AXI4 bandwidth meter: snoops W/B/R handshakes for one test run and freezes the totals.
// Optional response-error counting is enabled by defining AXI_BW_METER_RESP_ERR_EN.
module axi_bw_meter
    import axi_bw_meter_pkg::*;
#(
    parameter int C_CNT_WIDTH = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   init_txn,
    input  logic                   txn_done,
    input  logic                   wvalid,
    input  logic                   wready,
    input  logic                   wlast,
    input  logic                   bvalid,
    input  logic                   bready,
    input  logic [1:0]             bresp,
    input  logic                   rvalid,
    input  logic                   rready,
    input  logic                   rlast,
    input  logic [1:0]             rresp,
    output logic                   busy,
    output logic                   result_valid,
    output logic                   overflow,
    output logic [C_CNT_WIDTH-1:0] cyc_cnt,
    output logic [C_CNT_WIDTH-1:0] wr_beats,
    output logic [C_CNT_WIDTH-1:0] wr_bursts,
    output logic [C_CNT_WIDTH-1:0] wr_first,
    output logic [C_CNT_WIDTH-1:0] wr_last,
    output logic [C_CNT_WIDTH-1:0] rd_beats,
    output logic [C_CNT_WIDTH-1:0] rd_bursts,
    output logic [C_CNT_WIDTH-1:0] rd_first,
    output logic [C_CNT_WIDTH-1:0] rd_last,
    output logic [C_CNT_WIDTH-1:0] resp_err_cnt
);

    state_e                 state_q, state_d;
    logic                   init_q, done_q, armed_q;
    logic                   init_rise, done_rise, count_en;
    logic                   w_hs, b_hs, r_hs;
    logic [C_CNT_WIDTH-1:0] cyc_q, cyc_d, k_now;
    logic                   result_valid_q, result_valid_d;
    logic                   overflow_q, overflow_d;
    sat_res_t               cyc_res;
    logic                   wr_sat, rd_sat, err_sat;
    logic                   unused_misc;

    // armed_q masks the first cycle after reset so a level already high at release is not a rise.
    assign init_rise = init_txn & ~init_q & armed_q;
    assign done_rise = txn_done & ~done_q & armed_q;
    assign count_en  = (state_q == RUN) & ~init_rise;

    assign w_hs = wvalid & wready;
    assign b_hs = bvalid & bready;
    assign r_hs = rvalid & rready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init_rise) state_d = RUN;
            RUN:     if (init_rise) state_d = RUN;
                     else if (done_rise) state_d = HOLD;
            HOLD:    if (init_rise) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cyc_res        = sat_inc(MAX_W'(cyc_q), 2'd1, C_CNT_WIDTH);
        k_now          = cyc_res.value[C_CNT_WIDTH-1:0];
        cyc_d          = cyc_q;
        result_valid_d = result_valid_q;
        overflow_d     = overflow_q;
        if (init_rise) begin
            cyc_d          = '0;
            result_valid_d = 1'b0;
            overflow_d     = 1'b0;
        end else if (count_en) begin
            cyc_d = k_now;
            if (done_rise) result_valid_d = 1'b1;
            if (cyc_res.sat | wr_sat | rd_sat | err_sat) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q        <= IDLE;
            init_q         <= 1'b0;
            done_q         <= 1'b0;
            armed_q        <= 1'b0;
            cyc_q          <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_q         <= init_txn;
            done_q         <= txn_done;
            armed_q        <= 1'b1;
            cyc_q          <= cyc_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
        end
    end

    // Write bursts are closed by the B handshake, so wlast carries no extra information.
    axi_bw_ch_cnt #(.W(C_CNT_WIDTH)) u_wr (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .clear     (init_rise),
        .enable    (count_en),
        .beat      (w_hs),
        .burst_end (b_hs),
        .k         (k_now),
        .beats     (wr_beats),
        .bursts    (wr_bursts),
        .first     (wr_first),
        .last      (wr_last),
        .sat       (wr_sat)
    );

    axi_bw_ch_cnt #(.W(C_CNT_WIDTH)) u_rd (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .clear     (init_rise),
        .enable    (count_en),
        .beat      (r_hs),
        .burst_end (r_hs & rlast),
        .k         (k_now),
        .beats     (rd_beats),
        .bursts    (rd_bursts),
        .first     (rd_first),
        .last      (rd_last),
        .sat       (rd_sat)
    );

`ifdef AXI_BW_METER_RESP_ERR_EN
    logic [C_CNT_WIDTH-1:0] err_q, err_d;
    logic [1:0]             err_inc;
    sat_res_t               err_res;
    logic                   unused_err_wide;

    always_comb begin
        err_inc = {1'b0, b_hs && (bresp != OKAY_RESP)} + {1'b0, r_hs && (rresp != OKAY_RESP)};
        err_res = sat_inc(MAX_W'(err_q), err_inc, C_CNT_WIDTH);
        err_d   = err_q;
        if (init_rise)     err_d = '0;
        else if (count_en) err_d = err_res.value[C_CNT_WIDTH-1:0];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) err_q <= '0;
        else          err_q <= err_d;
    end

    assign err_sat         = count_en & err_res.sat;
    assign resp_err_cnt    = err_q;
    assign unused_err_wide = ^err_res.value;
`else
    logic unused_resp;
    assign unused_resp  = ^{bresp, rresp, OKAY_RESP};
    assign err_sat      = 1'b0;
    assign resp_err_cnt = '0;
`endif

    assign unused_misc  = ^{wlast, cyc_res.value};
    assign busy         = (state_q == RUN);
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign cyc_cnt      = cyc_q;

endmodule

// File: tb/tb_axi_bw_meter.sv
// Bench for axi_bw_meter: directed scenarios and randomized runs checked against a counting model,
// on a full-width instance and a 4-bit instance sharing the same stimulus.
module tb_axi_bw_meter;

    localparam int MAXK = 128;

    typedef struct packed {
        logic        busy;
        logic        rv;
        logic        ovf;
        logic [31:0] cyc;
        logic [31:0] wb;
        logic [31:0] wbu;
        logic [31:0] wf;
        logic [31:0] wl;
        logic [31:0] rb;
        logic [31:0] rbu;
        logic [31:0] rf;
        logic [31:0] rl;
        logic [31:0] err;
    } res_t;

    logic ACLK;
    logic ARESETN;
    logic init_txn, txn_done;
    logic wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast;
    logic [1:0] bresp, rresp;

    logic        busy32, rv32, ovf32;
    logic [31:0] cyc32, wb32, wbu32, wf32, wl32, rb32, rbu32, rf32, rl32, err32;
    logic        busy4, rv4, ovf4;
    logic [3:0]  cyc4, wb4, wbu4, wf4, wl4, rb4, rbu4, rf4, rl4, err4;

    bit         wv_a[MAXK], wr_a[MAXK], bv_a[MAXK], br_a[MAXK];
    bit         rv_a[MAXK], rr_a[MAXK], rl_a[MAXK];
    logic [1:0] bresp_a[MAXK], rresp_a[MAXK];

    int   total = 0;
    int   bad   = 0;
    res_t after_init32, after_init4;
    logic busy_k1;

    axi_bw_meter #(.C_CNT_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .init_txn(init_txn), .txn_done(txn_done),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .bvalid(bvalid), .bready(bready),
        .bresp(bresp), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .busy(busy32), .result_valid(rv32), .overflow(ovf32), .cyc_cnt(cyc32),
        .wr_beats(wb32), .wr_bursts(wbu32), .wr_first(wf32), .wr_last(wl32),
        .rd_beats(rb32), .rd_bursts(rbu32), .rd_first(rf32), .rd_last(rl32),
        .resp_err_cnt(err32)
    );

    axi_bw_meter #(.C_CNT_WIDTH(4)) dut4 (
        .ACLK(ACLK), .ARESETN(ARESETN), .init_txn(init_txn), .txn_done(txn_done),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .bvalid(bvalid), .bready(bready),
        .bresp(bresp), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .busy(busy4), .result_valid(rv4), .overflow(ovf4), .cyc_cnt(cyc4),
        .wr_beats(wb4), .wr_bursts(wbu4), .wr_first(wf4), .wr_last(wl4),
        .rd_beats(rb4), .rd_bursts(rbu4), .rd_first(rf4), .rd_last(rl4),
        .resp_err_cnt(err4)
    );

    // ---------------- clock ----------------
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // ---------------- observation and model ----------------
    function automatic res_t obs32();
        res_t r;
        r.busy = busy32; r.rv = rv32; r.ovf = ovf32; r.cyc = cyc32;
        r.wb = wb32; r.wbu = wbu32; r.wf = wf32; r.wl = wl32;
        r.rb = rb32; r.rbu = rbu32; r.rf = rf32; r.rl = rl32; r.err = err32;
        return r;
    endfunction

    function automatic res_t obs4();
        res_t r;
        r.busy = busy4; r.rv = rv4; r.ovf = ovf4; r.cyc = 32'(cyc4);
        r.wb = 32'(wb4); r.wbu = 32'(wbu4); r.wf = 32'(wf4); r.wl = 32'(wl4);
        r.rb = 32'(rb4); r.rbu = 32'(rbu4); r.rf = 32'(rf4); r.rl = 32'(rl4); r.err = 32'(err4);
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("busy=%0d rv=%0d ovf=%0d cyc=%0d wb=%0d wbu=%0d wf=%0d wl=%0d rb=%0d rbu=%0d rf=%0d rl=%0d err=%0d",
                         r.busy, r.rv, r.ovf, r.cyc, r.wb, r.wbu, r.wf, r.wl, r.rb, r.rbu, r.rf, r.rl, r.err);
    endfunction

    function automatic longint capv(input longint x, input longint mx);
        return (x > mx) ? mx : x;
    endfunction

    // Expected frozen results of a completed run of n cycles, for a counter width w.
    function automatic res_t model(input int n, input int w);
        res_t   e;
        longint mx, wb, wbu, wf, wl, rb, rbu, rf, rl, err;
        mx = (longint'(1) << w) - 1;
        wb = 0; wbu = 0; wf = 0; wl = 0; rb = 0; rbu = 0; rf = 0; rl = 0; err = 0;
        for (int k = 1; k <= n; k++) begin
            if (wv_a[k] && wr_a[k]) begin
                wb++;
                if (wf == 0) wf = k;
            end
            if (bv_a[k] && br_a[k]) begin
                wbu++;
                wl = k;
                if (bresp_a[k] != 2'b00) err++;
            end
            if (rv_a[k] && rr_a[k]) begin
                rb++;
                if (rf == 0) rf = k;
                if (rl_a[k]) begin
                    rbu++;
                    rl = k;
                end
                if (rresp_a[k] != 2'b00) err++;
            end
        end
`ifndef AXI_BW_METER_RESP_ERR_EN
        err = 0;
`endif
        e.busy = 1'b0;
        e.rv   = 1'b1;
        e.ovf  = (n > mx) || (wb > mx) || (wbu > mx) || (rb > mx) || (rbu > mx) || (err > mx);
        e.cyc  = 32'(capv(n, mx));
        e.wb   = 32'(capv(wb, mx));
        e.wbu  = 32'(capv(wbu, mx));
        e.wf   = 32'(capv(wf, mx));
        e.wl   = 32'(capv(wl, mx));
        e.rb   = 32'(capv(rb, mx));
        e.rbu  = 32'(capv(rbu, mx));
        e.rf   = 32'(capv(rf, mx));
        e.rl   = 32'(capv(rl, mx));
        e.err  = 32'(capv(err, mx));
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_bus();
        wvalid = 0; wready = 0; wlast = 0; bvalid = 0; bready = 0; bresp = 2'b00;
        rvalid = 0; rready = 0; rlast = 0; rresp = 2'b00;
    endtask

    task automatic clear_stim();
        for (int k = 0; k < MAXK; k++) begin
            wv_a[k] = 0; wr_a[k] = 0; bv_a[k] = 0; br_a[k] = 0;
            rv_a[k] = 0; rr_a[k] = 0; rl_a[k] = 0;
            bresp_a[k] = 2'b00; rresp_a[k] = 2'b00;
        end
    endtask

    // Init rise at cycle 0 (with handshakes that must be ignored), stimulus for k=1..n, done rise at k=n.
    task automatic exec_run(input int n);
        idle_bus();
        init_txn = 0;
        txn_done = 0;
        step();
        init_txn = 1;
        wvalid = 1; wready = 1; wlast = 1; bvalid = 1; bready = 1; bresp = 2'b10;
        rvalid = 1; rready = 1; rlast = 1; rresp = 2'b11;
        step();
        after_init32 = obs32();
        after_init4  = obs4();
        init_txn = 0;
        for (int k = 1; k <= n; k++) begin
            wvalid = wv_a[k]; wready = wr_a[k]; wlast = 0;
            bvalid = bv_a[k]; bready = br_a[k]; bresp = bresp_a[k];
            rvalid = rv_a[k]; rready = rr_a[k]; rlast = rl_a[k]; rresp = rresp_a[k];
            txn_done = (k == n);
            step();
            if (k == 1) busy_k1 = busy32;
        end
        idle_bus();
        txn_done = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        res_t exp_r, got_r;
        exp_r = '0;
        ARESETN = 0;
        init_txn = 0;
        txn_done = 0;
        idle_bus();
        for (int i = 0; i < 20; i++) begin
            init_txn = 1'($urandom_range(0, 1)); txn_done = 1'($urandom_range(0, 1));
            wvalid = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1));
            bvalid = 1'($urandom_range(0, 1)); bready = 1'($urandom_range(0, 1));
            rvalid = 1'($urandom_range(0, 1)); rready = 1'($urandom_range(0, 1));
            rlast = 1'($urandom_range(0, 1)); bresp = 2'($urandom_range(0, 3)); rresp = 2'($urandom_range(0, 3));
            step();
        end
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL reset_hold_32: got %s want %s", fmt(got_r), fmt(exp_r)); end
        got_r = obs4(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL reset_hold_4: got %s want %s", fmt(got_r), fmt(exp_r)); end
        idle_bus();
        init_txn = 0;
        txn_done = 0;
        ARESETN = 1;
        repeat (5) step();
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL reset_release_idle: got %s want %s", fmt(got_r), fmt(exp_r)); end
    endtask

    task automatic test_single_write();
        res_t exp_r, got_r;
        clear_stim();
        for (int k = 3; k <= 18; k++) begin wv_a[k] = 1; wr_a[k] = 1; end
        bv_a[20] = 1; br_a[20] = 1;
        exec_run(25);
        total++;
        if (busy_k1 !== 1'b1) begin bad++; $display("FAIL busy_during_run: got %0d want 1", busy_k1); end
        exp_r = '0;
        exp_r.rv = 1; exp_r.cyc = 25; exp_r.wb = 16; exp_r.wbu = 1; exp_r.wf = 3; exp_r.wl = 20;
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL single_write_32: got %s want %s", fmt(got_r), fmt(exp_r)); end
        got_r = obs4(); total++;
        if (got_r !== model(25, 4)) begin bad++; $display("FAIL single_write_4: got %s want %s", fmt(got_r), fmt(model(25, 4))); end
        wvalid = 1; wready = 1; bvalid = 1; bready = 1; rvalid = 1; rready = 1; rlast = 1;
        txn_done = 1;
        repeat (5) step();
        idle_bus();
        txn_done = 0;
        step();
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL hold_frozen: got %s want %s", fmt(got_r), fmt(exp_r)); end
    endtask

    task automatic test_gapped_read();
        res_t exp_r, got_r;
        clear_stim();
        for (int k = 5; k <= 35; k++) begin rv_a[k] = 1; rr_a[k] = (k % 2) == 1; end
        rl_a[19] = 1; rl_a[20] = 1; rl_a[35] = 1;
        exec_run(38);
        exp_r = '0;
        exp_r.rv = 1; exp_r.cyc = 38; exp_r.rb = 16; exp_r.rbu = 2; exp_r.rf = 5; exp_r.rl = 35;
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL gapped_read_32: got %s want %s", fmt(got_r), fmt(exp_r)); end
        got_r = obs4(); total++;
        if (got_r !== model(38, 4)) begin bad++; $display("FAIL gapped_read_4: got %s want %s", fmt(got_r), fmt(model(38, 4))); end
    endtask

    task automatic test_saturation();
        res_t exp_r, got_r;
        clear_stim();
        for (int k = 1; k <= 20; k++) begin wv_a[k] = 1; wr_a[k] = 1; end
        exec_run(22);
        exp_r = '0;
        exp_r.rv = 1; exp_r.ovf = 1; exp_r.cyc = 15; exp_r.wb = 15; exp_r.wf = 1;
        got_r = obs4(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL sat_width4: got %s want %s", fmt(got_r), fmt(exp_r)); end
        got_r = obs32(); total++;
        if (got_r !== model(22, 32)) begin bad++; $display("FAIL sat_width32: got %s want %s", fmt(got_r), fmt(model(22, 32))); end
        clear_stim();
        exec_run(3);
        exp_r = '0;
        exp_r.busy = 1;
        total++;
        if (after_init4 !== exp_r) begin bad++; $display("FAIL sat_clear_on_init: got %s want %s", fmt(after_init4), fmt(exp_r)); end
        got_r = obs4(); total++;
        if (got_r !== model(3, 4)) begin bad++; $display("FAIL sat_short_run: got %s want %s", fmt(got_r), fmt(model(3, 4))); end
    endtask

    task automatic test_restart_hold();
        res_t exp_r, got_r;
        clear_stim();
        for (int k = 2; k <= 6; k++) begin wv_a[k] = 1; wr_a[k] = 1; end
        bv_a[8] = 1; br_a[8] = 1;
        exec_run(10);
        clear_stim();
        rv_a[2] = 1; rr_a[2] = 1; rl_a[2] = 1;
        exec_run(4);
        exp_r = '0;
        exp_r.busy = 1;
        total++;
        if (after_init32 !== exp_r) begin bad++; $display("FAIL restart_in_hold: got %s want %s", fmt(after_init32), fmt(exp_r)); end
        got_r = obs32(); total++;
        if (got_r !== model(4, 32)) begin bad++; $display("FAIL restart_run_result: got %s want %s", fmt(got_r), fmt(model(4, 32))); end
    endtask

    task automatic test_init_done_same();
        res_t exp_r, got_r;
        idle_bus();
        init_txn = 0;
        txn_done = 0;
        step();
        init_txn = 1;
        step();
        init_txn = 0;
        wvalid = 1; wready = 1;
        repeat (6) step();
        init_txn = 1;
        txn_done = 1;
        step();
        exp_r = '0;
        exp_r.busy = 1;
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL same_cycle_restart: got %s want %s", fmt(got_r), fmt(exp_r)); end
        init_txn = 0;
        txn_done = 0;
        idle_bus();
        repeat (3) step();
        exp_r.cyc = 3;
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL after_restart_count: got %s want %s", fmt(got_r), fmt(exp_r)); end
        txn_done = 1;
        step();
        txn_done = 0;
        exp_r.busy = 0; exp_r.rv = 1; exp_r.cyc = 4;
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL after_restart_done: got %s want %s", fmt(got_r), fmt(exp_r)); end
    endtask

    task automatic test_reset_mid_run();
        res_t exp_r, got_r;
        idle_bus();
        init_txn = 0;
        txn_done = 0;
        step();
        init_txn = 1;
        step();
        init_txn = 0;
        wvalid = 1; wready = 1; bvalid = 1; bready = 1;
        repeat (8) step();
        ARESETN = 0;
        #1;
        exp_r = '0;
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL reset_mid_run_32: got %s want %s", fmt(got_r), fmt(exp_r)); end
        got_r = obs4(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL reset_mid_run_4: got %s want %s", fmt(got_r), fmt(exp_r)); end
        step();
        init_txn = 1;
        ARESETN = 1;
        repeat (5) step();
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL init_high_at_release: got %s want %s", fmt(got_r), fmt(exp_r)); end
        init_txn = 0;
        idle_bus();
        repeat (2) step();
    endtask

    task automatic test_done_idle();
        res_t exp_r, got_r;
        ARESETN = 0;
        idle_bus();
        init_txn = 0;
        txn_done = 0;
        step();
        ARESETN = 1;
        repeat (3) step();
        wvalid = 1; wready = 1;
        txn_done = 1;
        repeat (2) step();
        txn_done = 0;
        idle_bus();
        step();
        exp_r = '0;
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL done_in_idle: got %s want %s", fmt(got_r), fmt(exp_r)); end
    endtask

    task automatic test_resp_err();
        res_t exp_r, got_r;
        clear_stim();
        bv_a[2] = 1; br_a[2] = 1; bresp_a[2] = 2'b00;
        bv_a[4] = 1; br_a[4] = 1; bresp_a[4] = 2'b10;
        bv_a[6] = 1; br_a[6] = 1; bresp_a[6] = 2'b00;
        exec_run(8);
        exp_r = '0;
        exp_r.rv = 1; exp_r.cyc = 8; exp_r.wbu = 3; exp_r.wl = 6;
`ifdef AXI_BW_METER_RESP_ERR_EN
        exp_r.err = 1;
`else
        exp_r.err = 0;
`endif
        got_r = obs32(); total++;
        if (got_r !== exp_r) begin bad++; $display("FAIL resp_err: got %s want %s", fmt(got_r), fmt(exp_r)); end
    endtask

    task automatic test_random();
        res_t got_r;
        int   n, p;
        for (int it = 0; it < 10; it++) begin
            clear_stim();
            n = $urandom_range(6, 45);
            p = $urandom_range(20, 90);
            for (int k = 1; k <= n; k++) begin
                wv_a[k] = ($urandom_range(0, 99) < p); wr_a[k] = ($urandom_range(0, 99) < p);
                bv_a[k] = ($urandom_range(0, 99) < 30); br_a[k] = ($urandom_range(0, 99) < p);
                rv_a[k] = ($urandom_range(0, 99) < p); rr_a[k] = ($urandom_range(0, 99) < p);
                rl_a[k] = ($urandom_range(0, 99) < 25);
                bresp_a[k] = 2'($urandom_range(0, 3));
                rresp_a[k] = 2'($urandom_range(0, 3));
            end
            exec_run(n);
            got_r = obs32(); total++;
            if (got_r !== model(n, 32)) begin bad++; $display("FAIL random_32 it=%0d: got %s want %s", it, fmt(got_r), fmt(model(n, 32))); end
            got_r = obs4(); total++;
            if (got_r !== model(n, 4)) begin bad++; $display("FAIL random_4 it=%0d: got %s want %s", it, fmt(got_r), fmt(model(n, 4))); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_done_idle();
        test_single_write();
        test_gapped_read();
        test_saturation();
        test_restart_hold();
        test_init_done_same();
        test_reset_mid_run();
        test_resp_err();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_bw_meter.md
# axi_bw_meter

Passive AXI4 bandwidth meter that sits directly downstream of the AXI full master in the bus-bandwidth test system. It snoops the master's W/B/R handshakes and its INIT_AXI_TXN/TXN_DONE pair, and reports the following for one test run, frozen until the next run:
- cycle count;
- beat and burst counts per direction;
- first/last activity timestamps per direction.

It never drives the AXI bus.

## Interface
Parameters:
- C_CNT_WIDTH, 32, width of every counter and timestamp output (min 4).

Ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- init_txn  in  1  master start request (same net as master INIT_AXI_TXN); level, rising edge used.
- txn_done  in  1  master completion (same net as TXN_DONE); level, rising edge used.
- wvalid, wready, wlast  in  1 each  write data channel snoop.
- bvalid, bready  in  1 each  write response snoop.
- bresp  in  2  write response code.
- rvalid, rready, rlast  in  1 each  read data channel snoop.
- rresp  in  2  read response code.
- busy  out  1  meter in RUN.
- result_valid  out  1  results frozen and valid.
- overflow  out  1  sticky; any counter saturated this run.
- cyc_cnt  out  C_CNT_WIDTH  RUN cycles elapsed.
- wr_beats, wr_bursts, wr_first, wr_last  out  C_CNT_WIDTH each  write statistics.
- rd_beats, rd_bursts, rd_first, rd_last  out  C_CNT_WIDTH each  read statistics.
- resp_err_cnt  out  C_CNT_WIDTH  non-OKAY responses.

## Operation
- Edge detect: init_txn and txn_done are each registered once; a rise is current=1 while the registered value=0. Registers reset to 0.
- FSM states: IDLE, RUN, HOLD.
  - IDLE, init rise → RUN.
  - RUN, init rise → RUN, restart.
  - RUN, done rise with no init rise → HOLD.
  - HOLD, init rise → RUN.
  - All other cases: stay in the current state.
  - Done rise in IDLE or HOLD: ignored.
- Restart, on any init rise: in that cycle every counter, timestamp, overflow and result_valid are cleared to 0. Handshakes in that cycle are not counted.
- RUN cycles are numbered k = 1, 2, … starting with the cycle after the init rise. cyc_cnt holds k after cycle k. The done-rise cycle is counted.
- Write events:
  - beat = wvalid&wready.
  - burst = bvalid&bready. wr_bursts increments per B handshake.
  - wr_first = k of the first W beat.
  - wr_last = k of the most recent B handshake.
- Read events:
  - beat = rvalid&rready.
  - burst = beat&rlast.
  - rd_first = k of the first R beat.
  - rd_last = k of the most recent rlast beat.
- Timestamps with no event this run stay 0.
- Arithmetic: all increments saturate at 2^C_CNT_WIDTH−1. Any saturated increment attempt sets overflow, which is held until the next restart. Timestamps are taken from the saturated k.
- Counting is enabled only in RUN (including the done-rise cycle). In IDLE and HOLD, all outputs hold their values.

## Timing
- Reset values: state IDLE; every output 0.
- All outputs are registered. An event in cycle k is visible at the outputs at cycle k+1.
- busy is 1 from the cycle after the init rise until the cycle after the done rise.
- result_valid rises 1 cycle after the done rise, in the same cycle busy falls.
- Init rise and done rise in the same RUN cycle: restart wins; result_valid stays 0.
- Reset asserted mid-run: everything clears immediately. After release, a fresh init rise is required. An init_txn already high at release produces no rise.

## Configuration
- AXI_BW_METER_RESP_ERR_EN
  - Defined: resp_err_cnt increments, saturating, on each B handshake with bresp≠2'b00 and each R beat with rresp≠2'b00. If both occur in one cycle, it increments by 2.
  - Undefined: bresp and rresp are ignored; resp_err_cnt is constant 0 and never sets overflow.
- The port list is identical in both builds.

## Structure
- axi_bw_meter_pkg:
  - state enum (IDLE, RUN, HOLD);
  - OKAY response constant 2'b00;
  - saturating-increment function, returning the value and a saturate flag.
- Sub-module axi_bw_ch_cnt:
  - inputs: clear, enable, beat, burst_end, k;
  - outputs: beats, bursts, first, last, sat.
  - Instantiated twice, for write and read.
- The top module holds the edge detect, FSM, cyc_cnt, the response-error counter and the overflow OR.

## Test plan
- Reset: ARESETN low 20 cycles, with random bus activity → every output 0. Idle bus after release → still 0.
- Single write burst:
  - Stimulus: init rise at cycle 0; 16 W beats at k=3..18 (wlast at 18); B handshake at k=20; done rise at k=25.
  - Expected: wr_beats=16, wr_bursts=1, wr_first=3, wr_last=20, cyc_cnt=25; result_valid=1 and busy=0 at k=26; read outputs 0.
- Gapped read:
  - Stimulus: 2 bursts of 8 beats with rready toggling every cycle; first beat at k=5, rlast beats at k=19 and k=35.
  - Expected: rd_beats=16, rd_bursts=2, rd_first=5, rd_last=35.
- Saturation with C_CNT_WIDTH=4: 20 W beats → wr_beats=15, overflow=1. A later init rise clears overflow to 0.
- Restart cases:
  - Init rise in HOLD → all counters 0, busy=1.
  - Init rise and done rise in the same RUN cycle → remains in RUN, result_valid=0.
  - Done rise in IDLE → no change.
- Response errors: 3 B handshakes with bresp=2'b00, 2'b10, 2'b00 → resp_err_cnt=1 with AXI_BW_METER_RESP_ERR_EN defined, 0 without it.
